// File: rtl/genesis_pad_reader_if.sv
// Pad-side pins and console-side results of the Genesis pad reader, bundled as one port.
// Latency: none (wires only).
// Backpressure: none; every result is a pulse or level the consumer must take as it comes.
// Ports: pin0/1/2/3/5/8 pad data (active-low), pin6 pad select,
//        buttons/pressed/valid/connected results, curr FSM debug code.
interface genesis_pad_reader_if;
  logic       pin0;
  logic       pin1;
  logic       pin2;
  logic       pin3;
  logic       pin5;
  logic       pin8;
  logic       pin6;
  logic [7:0] buttons;
  logic [7:0] pressed;
  logic       valid;
  logic       connected;
  logic [3:0] curr;

  // Reader side: samples the pad and produces results.
  modport master (
    input  pin0, pin1, pin2, pin3, pin5, pin8,
    output pin6, buttons, pressed, valid, connected, curr
  );

  // Pad plus console side: drives the data pins and consumes results.
  modport slave (
    output pin0, pin1, pin2, pin3, pin5, pin8,
    input  pin6, buttons, pressed, valid, connected, curr
  );
endinterface

// File: rtl/genesis_pad_reader.sv
// Scans a 3-button Genesis pad in two select phases, debounces across polls, reports buttons.
// Latency: poll tick to valid pulse is 2*SETTLE_CYCLES+4 clk cycles.
// Backpressure: none; valid/pressed are single-cycle pulses once per POLL_DIV cycles.
// Ports: clk, reset (sync, active-high); bus (master modport):
//   pin0..pin8 pad data in, pin6 select out, buttons/pressed/valid/connected/curr out.
module genesis_pad_reader #(
  parameter int POLL_DIV      = 833333,
  parameter int SETTLE_CYCLES = 64,
  parameter int DEBOUNCE_N    = 2
) (
  input logic                  clk,
  input logic                  reset,
  genesis_pad_reader_if.master bus
);

  localparam int TW = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int DW = $clog2(DEBOUNCE_N + 1);

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    SETTLE_HI = 4'd1,
    SAMPLE_HI = 4'd2,
    SETTLE_LO = 4'd3,
    SAMPLE_LO = 4'd4,
    UPDATE    = 4'd5
  } state_t;

  state_t        state;
  logic [TW-1:0] timer;
  logic          tick;
  logic [SW-1:0] settle_cnt;
  logic [5:0]    sync1;
  logic [5:0]    sync2;
  logic [5:0]    hi;     // {pin8,pin5,pin3,pin2,pin1,pin0} with select high
  logic [3:0]    lo;     // {pin8,pin5,pin3,pin2} with select low
  logic          det;
  logic [7:0]    raw;
  logic [7:0]    cand;
  logic [DW-1:0] cnt;
  logic [7:0]    cand_next;
  logic [DW-1:0] cnt_next;
  logic [7:0]    new_buttons;
  logic          pin6_q;
  logic [7:0]    buttons_q;
  logic [7:0]    pressed_q;
  logic          valid_q;
  logic          connected_q;

  // Two-flop synchronizers; idle-high so a reset looks like a released pad.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= {bus.pin8, bus.pin5, bus.pin3, bus.pin2, bus.pin1, bus.pin0};
      sync2 <= sync1;
    end
  end

  // Free-running poll timer; tick marks its last value.
  assign tick = (timer == TW'(POLL_DIV - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      timer <= '0;
    end else if (tick) begin
      timer <= '0;
    end else begin
      timer <= timer + TW'(1);
    end
  end

  // A real pad pulls Left/Right low while select is low; absence means unplugged.
  assign det = ~lo[1] & ~lo[0];
  assign raw = det ? {~lo[3], ~hi[5], ~hi[4], ~lo[2], ~hi[3], ~hi[2], ~hi[1], ~hi[0]}
                   : 8'h00;

  // Debounce: count identical polls, saturating at DEBOUNCE_N.
  always_comb begin
    cand_next = cand;
    cnt_next  = cnt;
    if (raw == cand) begin
      if (cnt != DW'(DEBOUNCE_N)) begin
        cnt_next = cnt + DW'(1);
      end
    end else begin
      cand_next = raw;
      cnt_next  = DW'(1);
    end
    new_buttons = (cnt_next == DW'(DEBOUNCE_N)) ? cand_next : buttons_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      settle_cnt  <= '0;
      hi          <= '1;
      lo          <= '1;
      cand        <= '0;
      cnt         <= '0;
      pin6_q      <= 1'b1;
      buttons_q   <= '0;
      pressed_q   <= '0;
      valid_q     <= 1'b0;
      connected_q <= 1'b0;
    end else begin
      valid_q   <= 1'b0;
      pressed_q <= '0;
      case (state)
        IDLE: begin
          pin6_q <= 1'b1;
          if (tick) begin
            state      <= SETTLE_HI;
            settle_cnt <= '0;
          end
        end
        SETTLE_HI: begin
          if (settle_cnt == SW'(SETTLE_CYCLES - 1)) begin
            state <= SAMPLE_HI;
          end else begin
            settle_cnt <= settle_cnt + SW'(1);
          end
        end
        SAMPLE_HI: begin
          hi         <= sync2;
          pin6_q     <= 1'b0;
          settle_cnt <= '0;
          state      <= SETTLE_LO;
        end
        SETTLE_LO: begin
          if (settle_cnt == SW'(SETTLE_CYCLES - 1)) begin
            state <= SAMPLE_LO;
          end else begin
            settle_cnt <= settle_cnt + SW'(1);
          end
        end
        SAMPLE_LO: begin
          lo     <= sync2[5:2];
          pin6_q <= 1'b1;
          state  <= UPDATE;
        end
        UPDATE: begin
          cand        <= cand_next;
          cnt         <= cnt_next;
          buttons_q   <= new_buttons;
          pressed_q   <= new_buttons & ~buttons_q;
          connected_q <= det;
          valid_q     <= 1'b1;
          state       <= IDLE;
        end
        default: begin
          pin6_q <= 1'b1;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.pin6      = pin6_q;
  assign bus.buttons   = buttons_q;
  assign bus.pressed   = pressed_q;
  assign bus.valid     = valid_q;
  assign bus.connected = connected_q;
  assign bus.curr      = state;

endmodule

// File: tb/tb_genesis_pad_reader.sv
// Directed bench for genesis_pad_reader with a behavioural pad and a result scoreboard.
// Latency: expects valid 2*SETTLE_CYCLES+4 cycles after each poll tick.
// Backpressure: none; the bench samples every result on the falling edge.
module tb_genesis_pad_reader;

  localparam int POLL_DIV      = 64;
  localparam int SETTLE_CYCLES = 4;
  localparam int DEBOUNCE_N    = 2;
  localparam int FIRST_LAT     = POLL_DIV - 1 + 2 * SETTLE_CYCLES + 4;

  typedef struct packed {
    logic [7:0] buttons;
    logic [7:0] pressed;
    logic       connected;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       plugged = 1'b1;
  logic [7:0] btn = 8'h00;  // intended held buttons, active-high, same bit order as buttons
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         last_valid_cyc = 0;
  int         waited;
  exp_t       sb[$];

  genesis_pad_reader_if bus ();

  genesis_pad_reader #(
    .POLL_DIV     (POLL_DIV),
    .SETTLE_CYCLES(SETTLE_CYCLES),
    .DEBOUNCE_N   (DEBOUNCE_N)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Pad model: answers the select line combinationally, all pins high when unplugged.
  always_comb begin
    bus.pin0 = 1'b1;
    bus.pin1 = 1'b1;
    bus.pin2 = 1'b1;
    bus.pin3 = 1'b1;
    bus.pin5 = 1'b1;
    bus.pin8 = 1'b1;
    if (plugged) begin
      bus.pin0 = ~btn[0];
      bus.pin1 = ~btn[1];
      if (bus.pin6) begin
        bus.pin2 = ~btn[2];
        bus.pin3 = ~btn[3];
        bus.pin5 = ~btn[5];
        bus.pin8 = ~btn[6];
      end else begin
        bus.pin2 = 1'b0;
        bus.pin3 = 1'b0;
        bus.pin5 = ~btn[4];
        bus.pin8 = ~btn[7];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Queues the expected result, waits for the next valid, compares, then checks the pulses drop.
  task automatic do_poll(input string tag, input logic [7:0] eb, input logic [7:0] ep,
                         input logic ec, output int n);
    exp_t e;
    int   lows;
    logic got;
    e.buttons   = eb;
    e.pressed   = ep;
    e.connected = ec;
    sb.push_back(e);
    n    = 0;
    lows = 0;
    got  = 1'b0;
    while (!got && n < 4 * POLL_DIV) begin
      @(negedge clk);
      n++;
      if (bus.pin6 === 1'b0) lows++;
      if (bus.valid === 1'b1) got = 1'b1;
    end
    check({tag, "_valid_seen"}, {31'd0, got}, 32'd1);
    if (got && sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_buttons"}, {24'd0, bus.buttons}, {24'd0, e.buttons});
      check({tag, "_pressed"}, {24'd0, bus.pressed}, {24'd0, e.pressed});
      check({tag, "_connected"}, {31'd0, bus.connected}, {31'd0, e.connected});
      check({tag, "_pin6_low_cycles"}, lows, SETTLE_CYCLES + 1);
      last_valid_cyc = cyc;
      @(negedge clk);
      check({tag, "_valid_drop"}, {31'd0, bus.valid}, 32'd0);
      check({tag, "_pressed_drop"}, {24'd0, bus.pressed}, 32'd0);
    end
  endtask

  initial begin
    int prev;
    int guard;

    // 1: reset held three cycles, then idle state and first-poll latency.
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_pin6", {31'd0, bus.pin6}, 32'd1);
    check("rst_buttons", {24'd0, bus.buttons}, 32'd0);
    check("rst_pressed", {24'd0, bus.pressed}, 32'd0);
    check("rst_valid", {31'd0, bus.valid}, 32'd0);
    check("rst_connected", {31'd0, bus.connected}, 32'd0);
    check("rst_curr", {28'd0, bus.curr}, 32'd0);
    do_poll("first", 8'h00, 8'h00, 1'b1, waited);
    check("first_latency", waited, FIRST_LAT);

    // 2: connected, nothing pressed; polls spaced exactly POLL_DIV.
    prev = last_valid_cyc;
    do_poll("idle_a", 8'h00, 8'h00, 1'b1, waited);
    check("idle_a_period", last_valid_cyc - prev, POLL_DIV);
    prev = last_valid_cyc;
    do_poll("idle_b", 8'h00, 8'h00, 1'b1, waited);
    check("idle_b_period", last_valid_cyc - prev, POLL_DIV);

    // 3: A+Up needs two agreeing polls; one strobe only.
    btn = 8'h11;
    do_poll("au_k", 8'h00, 8'h00, 1'b1, waited);
    do_poll("au_k1", 8'h11, 8'h11, 1'b1, waited);
    do_poll("au_k2", 8'h11, 8'h00, 1'b1, waited);

    // 4: single-poll Start glitch is filtered out.
    btn = 8'h91;
    do_poll("glitch", 8'h11, 8'h00, 1'b1, waited);
    btn = 8'h11;
    do_poll("glitch_after", 8'h11, 8'h00, 1'b1, waited);
    do_poll("glitch_settled", 8'h11, 8'h00, 1'b1, waited);

    // 5: unplug reads as released; no strobe on release.
    plugged = 1'b0;
    do_poll("unplug_1", 8'h11, 8'h00, 1'b0, waited);
    do_poll("unplug_2", 8'h00, 8'h00, 1'b0, waited);

    // Remaining bit mapping: Start alone, then C/B/Right/Left/Down.
    plugged = 1'b1;
    btn = 8'h80;
    do_poll("start_1", 8'h00, 8'h00, 1'b1, waited);
    do_poll("start_2", 8'h80, 8'h80, 1'b1, waited);
    btn = 8'h6E;
    do_poll("dir_1", 8'h80, 8'h00, 1'b1, waited);
    do_poll("dir_2", 8'h6E, 8'h6E, 1'b1, waited);

    // 6: reset in SETTLE_LO aborts the poll; next poll waits for a full timer wrap.
    guard = 0;
    while (bus.curr !== 4'd3 && guard < 4 * POLL_DIV) begin
      @(negedge clk);
      guard++;
    end
    check("reach_settle_lo", {28'd0, bus.curr}, 32'd3);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_pin6", {31'd0, bus.pin6}, 32'd1);
    check("midrst_curr", {28'd0, bus.curr}, 32'd0);
    check("midrst_buttons", {24'd0, bus.buttons}, 32'd0);
    check("midrst_valid", {31'd0, bus.valid}, 32'd0);
    reset = 1'b0;
    do_poll("postrst_1", 8'h00, 8'h00, 1'b1, waited);
    check("postrst_latency", waited, FIRST_LAT);
    do_poll("postrst_2", 8'h6E, 8'h6E, 1'b1, waited);

    check("scoreboard_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
